// File: rtl/text_mode_ctrl.sv
// Text-mode VGA controller: 8-pixel-wide character cells from an internal
// screen RAM, external glyph ROM, blinking inverse cursor, write port with
// edge-triggered address stepping. Pixel-to-output latency is 3 clk.
module text_mode_ctrl #(
    parameter int H_VIS        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VIS        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CHAR_H       = 16,
    parameter int BLINK_FRAMES = 32,
    localparam int COLS   = H_VIS / 8,
    localparam int ROWS   = V_VIS / CHAR_H,
    localparam int CELLS  = COLS * ROWS,
    localparam int ADDR_W = $clog2(CELLS)
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wren_i,
    input  logic              addr_inc_i,
    input  logic              addr_inc_dir_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [11:0]       font_addr_o,
    input  logic [7:0]        font_data_i,
    input  logic [11:0]       fg_rgb_i,
    input  logic [11:0]       bg_rgb_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [3:0]        r_vga_o,
    output logic [3:0]        g_vga_o,
    output logic [3:0]        b_vga_o,
    output logic              frame_o
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = ADDR_W + 1;
    localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    // Base cell of the current text row; advanced by COLS at each row
    // boundary so no multiplier is needed. Saturates at CELLS in blanking.
    logic [BW-1:0]     r_row_base;

    logic [7:0]        r_mem [CELLS];
    logic [7:0]        r_char;
    logic [3:0]        r_sub1;
    logic [2:0]        r_px1, r_px2;
    logic [1:0]        r_vis_p, r_hs_p, r_vs_p, r_cur_p;

    logic              r_inc_prev;
    logic [BLK_W-1:0]  r_blk_cnt;
    logic              r_blink;

    logic              w_hvis, w_vvis, w_vis;
    logic              w_hs_raw, w_vs_raw;
    logic [3:0]        w_sub_row;
    logic              w_sub_last;
    logic [ADDR_W-1:0] w_col, w_rd_addr;
    logic              w_cur;
    logic              w_step;
    logic              w_pix;
    logic [11:0]       w_fg, w_bg, w_rgb;

    // S0 decode: visibility, raw syncs, screen RAM read address, cursor hit
    assign w_hvis     = (r_h_cnt < HW'(H_VIS));
    assign w_vvis     = (r_v_cnt < VW'(V_VIS));
    assign w_vis      = w_hvis && w_vvis;
    assign w_hs_raw   = !((r_h_cnt >= HW'(H_VIS + H_FP)) &&
                          (r_h_cnt <  HW'(H_VIS + H_FP + H_SYNC)));
    assign w_vs_raw   = !((r_v_cnt >= VW'(V_VIS + V_FP)) &&
                          (r_v_cnt <  VW'(V_VIS + V_FP + V_SYNC)));
    assign w_sub_row  = 4'(r_v_cnt & VW'(CHAR_H - 1));
    assign w_sub_last = (w_sub_row == 4'(CHAR_H - 1));
    assign w_col      = ADDR_W'(r_h_cnt >> 3);
    assign w_rd_addr  = w_vis ? (ADDR_W'(r_row_base) + w_col) : '0;
    assign w_cur      = w_vis && (w_rd_addr == addr_o);

    // Horizontal/vertical counters and incremental row base
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_row_base <= '0;
        end else if (r_h_cnt == HW'(H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            if (r_v_cnt == VW'(V_TOTAL - 1)) begin
                r_v_cnt    <= '0;
                r_row_base <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 1'b1;
                if (w_sub_last && (r_row_base < BW'(CELLS)))
                    r_row_base <= r_row_base + BW'(COLS);
            end
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Screen RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wren_i)
            r_mem[addr_o] <= wr_data_i;
    end

    // S1/S2: registered RAM read, then glyph ROM address; side-band delayed alongside
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_char      <= '0;
            r_sub1      <= '0;
            r_px1       <= '0;
            r_px2       <= '0;
            font_addr_o <= '0;
            r_vis_p     <= '0;
            r_cur_p     <= '0;
            r_hs_p      <= '1;
            r_vs_p      <= '1;
        end else begin
            r_char      <= r_mem[w_rd_addr];
            r_sub1      <= w_sub_row;
            r_px1       <= r_h_cnt[2:0];
            r_px2       <= r_px1;
            font_addr_o <= {r_char, r_sub1};
            r_vis_p     <= {r_vis_p[0], w_vis};
            r_cur_p     <= {r_cur_p[0], w_cur};
            r_hs_p      <= {r_hs_p[0], w_hs_raw};
            r_vs_p      <= {r_vs_p[0], w_vs_raw};
        end
    end

    // S3 colour select: glyph bit 7 is the leftmost pixel; cursor swaps fg/bg
    assign w_pix = font_data_i[3'd7 - r_px2];
    assign w_fg  = (r_cur_p[1] && r_blink) ? bg_rgb_i : fg_rgb_i;
    assign w_bg  = (r_cur_p[1] && r_blink) ? fg_rgb_i : bg_rgb_i;
    assign w_rgb = r_vis_p[1] ? (w_pix ? w_fg : w_bg) : 12'h000;

    // S3 output registers: colour and syncs leave on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            {r_vga_o, g_vga_o, b_vga_o} <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            {r_vga_o, g_vga_o, b_vga_o} <= w_rgb;
            hsync_o <= r_hs_p[1];
            vsync_o <= r_vs_p[1];
        end
    end

    // Frame pulse: registered one clk early so it is high exactly while
    // the counters sit at (h=0, v=V_VIS)
    always_ff @(posedge clk) begin
        if (!rst_n_i)
            frame_o <= 1'b0;
        else
            frame_o <= (r_h_cnt == HW'(H_TOTAL - 1)) && (r_v_cnt == VW'(V_VIS - 1));
    end

    // Cursor blink: toggle phase every BLINK_FRAMES frame pulses
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_blk_cnt <= '0;
            r_blink   <= 1'b0;
        end else if (frame_o) begin
            if (r_blk_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                r_blk_cnt <= '0;
                r_blink   <= ~r_blink;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    // Address stepping on the rising edge of addr_inc_i, wrapping within 0..CELLS-1.
    // The write above uses the pre-step addr_o of the same clk.
    assign w_step = addr_inc_i & ~r_inc_prev;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_inc_prev <= 1'b0;
            addr_o     <= '0;
        end else begin
            r_inc_prev <= addr_inc_i;
            if (w_step) begin
                if (addr_inc_dir_i)
                    addr_o <= (addr_o == ADDR_W'(CELLS - 1)) ? '0 : addr_o + 1'b1;
                else
                    addr_o <= (addr_o == '0) ? ADDR_W'(CELLS - 1) : addr_o - 1'b1;
            end
        end
    end

endmodule

// File: doc/text_mode_ctrl.md
TEXT_MODE_CTRL -- requirements
Module: text_mode_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_VIS 640: visible pixels per line; H_FP 16; H_SYNC 96; H_BP 48.
- V_VIS 480: visible lines; V_FP 10; V_SYNC 2; V_BP 33.
- CHAR_H 16: glyph rows, power of two, at most 16.
- BLINK_FRAMES 32: frames per cursor blink phase.
REQ-002 Derived localparams SHALL be:
- COLS = H_VIS/8.
- ROWS = V_VIS/CHAR_H.
- CELLS = COLS*ROWS.
- ADDR_W = clog2(CELLS).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  pixel clock; single clock domain.
- rst_n_i  in  1  reset; synchronous, active-low.
- wr_data_i  in  8  character code to write.
- wren_i  in  1  write strobe; writes wr_data_i to cell addr_o on every clk edge where high.
- addr_inc_i  in  1  address step request (level; rising edge acts).
- addr_inc_dir_i  in  1  step direction: 1 = +1, 0 = -1.
- addr_o  out  ADDR_W  current write/cursor cell address.
- font_addr_o  out  12  glyph ROM address {char[7:0], sub_row[3:0]}.
- font_data_i  in  8  glyph row; valid exactly one clk after font_addr_o.
- fg_rgb_i  in  12  foreground colour {r,g,b}.
- bg_rgb_i  in  12  background colour {r,g,b}.
- hsync_o  out  1  horizontal sync, active low.
- vsync_o  out  1  vertical sync, active low.
- r_vga_o, g_vga_o, b_vga_o  out  4 each  pixel colour.
- frame_o  out  1  one-cycle pulse at first blanked line of each frame.

Function
REQ-004 Screen RAM SHALL be internal, CELLS x 8 bits, one write port and one registered read port; contents are undefined after power-up and SHALL NOT be cleared by reset.
REQ-005 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP) and wrap to 0.
REQ-006 v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1, and wrap to 0.
REQ-007 Raw hsync SHALL be low while H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC; raw vsync follows the same rule on v_cnt.
REQ-008 Read address SHALL be (v_cnt/CHAR_H)*COLS + h_cnt/8, computed without a hardware multiplier wider than ADDR_W.
REQ-009 Pixel pipeline SHALL be four stages:
- S0: counters.
- S1: RAM read registered.
- S2: font_addr_o registered from S1 char and v_cnt mod CHAR_H, zero-extended to 4 bits.
- S3: font_data_i bit selected, colour registered to r/g/b_vga_o.
REQ-010 Pixel bit selection SHALL be font_data_i[7 - (h_cnt mod 8)], using h_cnt delayed to match; bit 7 is the leftmost pixel.
REQ-011 hsync_o, vsync_o and the visible flag SHALL be delayed by the same number of stages so they align with the RGB outputs.
REQ-012 RGB timing SHALL be as follows:
- RGB outputs SHALL equal 0 whenever the aligned position is outside the visible area.
- Inside the visible area, RGB SHALL be fg_rgb_i for a set bit and bg_rgb_i for a clear bit.
- Fixed latency: counter value to RGB/sync output is 3 clk.
REQ-013 Cursor SHALL be shown as follows:
- When the cell being drawn equals addr_o and blink_phase = 1, fg and bg SHALL be swapped for that cell.
- blink_phase SHALL toggle every BLINK_FRAMES frame_o pulses.
REQ-014 frame_o SHALL pulse for exactly one clk when h_cnt = 0 and v_cnt = V_VIS.
REQ-015 Address stepping SHALL act only on the rising edge of addr_inc_i, detected by registered previous value (high now, low previous clk); holding the input high SHALL step once.
REQ-016 Address wrap-around SHALL be as follows:
- Step +1 from CELLS-1 SHALL wrap to 0.
- Step -1 from 0 SHALL wrap to CELLS-1.
- addr_o never leaves 0..CELLS-1.
REQ-017 When wren_i and a step occur in the same clk, the write SHALL use the pre-step address; the new address takes effect next clk.
REQ-018 Read/write collision on the same cell SHALL return old or new data to the display, with no other effect; either is acceptable.

Reset
REQ-019 While rst_n_i is low at a clk edge, all of the following SHALL hold on the next edge:
- h_cnt = 0, v_cnt = 0, addr_o = 0.
- Pipeline registers cleared; RGB = 0; hsync_o = vsync_o = 1; frame_o = 0.
- font_addr_o = 0; blink_phase = 0; edge-detect register = 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame; timing restarts at h_cnt = 0, v_cnt = 0 on the first clk after release.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset with defaults: after release, count clk between hsync_o falling edges -> 800; lines between vsync_o falling edges -> 525; hsync low width 96 clk, vsync low width 2 lines.
- Write 0x41 at addr 0 with font model returning 0x80 for char 0x41 row 0, fg 0xFFF, bg 0x000 -> at line 0, first visible pixel is 0xFFF on all channels, next 7 pixels 0x000; first pixel appears 3 clk after h_cnt = 0.
- addr_o = CELLS-1 (2399), dir = 1, one rising edge -> addr_o = 0. Then dir = 0, edge -> 2399. Then hold addr_inc_i high 10 clk -> exactly one step.
- wren_i = 1 with wr_data_i = 0x55 and step edge in the same clk at addr 5 -> cell 5 holds 0x55, addr_o = 6.
- Run 32 frames with cursor at addr 0 -> cell 0 colours swap from frame 32 onward; frame_o count is 32.
- Assert rst_n_i low for 1 clk at mid-line 100 -> next clk RGB = 0, syncs high; timing restarts from (0,0) with RAM contents preserved.
